// File: rtl/dtw_cell_engine_if.sv
// Handshake bundle for dtw_cell_engine: template/query sample streams, result
// channel and status. The optional early-abandon signals are present only when
// DTW_EARLY_ABANDON_EN is defined.
interface dtw_cell_engine_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CWIDTH = 16
);
    logic              start;
    logic              tmpl_valid;
    logic              tmpl_ready;
    logic [WIDTH-1:0]  tmpl_data;
    logic              qry_valid;
    logic              qry_ready;
    logic [WIDTH-1:0]  qry_data;
    logic              dist_valid;
    logic              dist_ready;
    logic [CWIDTH-1:0] dist_data;
    logic              busy;
`ifdef DTW_EARLY_ABANDON_EN
    logic [CWIDTH-1:0] abandon_thresh;
    logic              abandoned;
`endif

    modport master (
`ifdef DTW_EARLY_ABANDON_EN
        output abandon_thresh,
        input  abandoned,
`endif
        output start, tmpl_valid, tmpl_data, qry_valid, qry_data, dist_ready,
        input  tmpl_ready, qry_ready, dist_valid, dist_data, busy
    );

    modport slave (
`ifdef DTW_EARLY_ABANDON_EN
        input  abandon_thresh,
        output abandoned,
`endif
        input  start, tmpl_valid, tmpl_data, qry_valid, qry_data, dist_ready,
        output tmpl_ready, qry_ready, dist_valid, dist_data, busy
    );
endinterface

// File: rtl/dtw_cell_engine.sv
// Banded (Sakoe-Chiba) dynamic-time-warping distance engine.
// Loads an N-sample template, then consumes the query one sample per row and
// evaluates one cost cell per cycle inside the band. Only the template and two
// band-wide rows are stored. Optional macro DTW_EARLY_ABANDON_EN adds an
// abandon threshold that terminates the comparison once a row minimum exceeds it.
module dtw_cell_engine #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CWIDTH = 16,
    parameter int unsigned N      = 16,
    parameter int unsigned R      = 2
) (
    input  logic              clk,
    input  logic              rst,
    dtw_cell_engine_if.slave  bus
);
    localparam int unsigned BW = 2 * R + 1;
    localparam int unsigned NW = $clog2(N);
    localparam int unsigned KW = $clog2(BW);
    localparam int unsigned IW = $clog2(N + R) + 1;
    localparam logic [CWIDTH-1:0] CMAX = '1;

    typedef enum logic [2:0] {IDLE, LOAD_T, WAIT_Q, ROW, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  tmpl_q [N];
    logic [WIDTH-1:0]  tmpl_d [N];
    logic [CWIDTH-1:0] prev_q [BW];
    logic [CWIDTH-1:0] prev_d [BW];
    logic [CWIDTH-1:0] cur_q  [BW];
    logic [CWIDTH-1:0] cur_d  [BW];
    logic [WIDTH-1:0]  x_q, x_d;
    logic [NW-1:0]     i_q, i_d;
    logic [NW-1:0]     j_q, j_d;
    logic [CWIDTH-1:0] row_min_q, row_min_d;
    logic              tmpl_ready_q, tmpl_ready_d;
    logic              qry_ready_q, qry_ready_d;
    logic              dist_valid_q, dist_valid_d;
    logic [CWIDTH-1:0] dist_data_q, dist_data_d;
    logic              busy_q, busy_d;
    logic              abandoned_q, abandoned_d;

    // Datapath for the current cell
    logic [IW-1:0]     i_w, j_w, k_w, j_lo, j_hi;
    logic [KW-1:0]     k, kp1;
    logic [WIDTH-1:0]  y_sel, diff;
    logic [CWIDTH-1:0] p_diag, p_up, p_left, min_pred, cost, row_min_next;
    logic [CWIDTH:0]   sum;
    logic              last_cell, abandon_hit;

    // Band geometry, predecessor selection and saturating cell cost
    always_comb begin
        i_w    = IW'(i_q);
        j_w    = IW'(j_q);
        j_lo   = (i_w > IW'(R)) ? (i_w - IW'(R)) : '0;
        j_hi   = ((i_w + IW'(R)) > IW'(N - 1)) ? IW'(N - 1) : (i_w + IW'(R));
        k_w    = j_w + IW'(R) - i_w;
        k      = KW'(k_w);
        kp1    = k + KW'(1);
        last_cell = (j_w == j_hi);

        y_sel  = tmpl_q[j_q];
        diff   = (x_q >= y_sel) ? (x_q - y_sel) : (y_sel - x_q);

        // Previous row is stored with band offset one lower, so D(i-1,j) sits at k+1
        p_diag = prev_q[k];
        p_up   = (kp1 < KW'(BW)) ? prev_q[kp1] : CMAX;
        p_left = (k == '0) ? CMAX : cur_q[k - KW'(1)];

        min_pred = p_diag;
        if (p_up < min_pred)   min_pred = p_up;
        if (p_left < min_pred) min_pred = p_left;
        if ((i_q == '0) && (j_q == '0)) min_pred = '0;

        sum  = {1'b0, CWIDTH'(diff)} + {1'b0, min_pred};
        cost = sum[CWIDTH] ? CMAX : sum[CWIDTH-1:0];

        row_min_next = (cost < row_min_q) ? cost : row_min_q;
        abandon_hit  = 1'b0;
`ifdef DTW_EARLY_ABANDON_EN
        abandon_hit  = (row_min_next > bus.abandon_thresh);
`endif
    end

    // Next-state and next-output computation
    always_comb begin
        state_d      = state_q;
        tmpl_d       = tmpl_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        x_d          = x_q;
        i_d          = i_q;
        j_d          = j_q;
        row_min_d    = row_min_q;
        dist_data_d  = dist_data_q;
        abandoned_d  = abandoned_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD_T;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            LOAD_T: begin
                if (bus.tmpl_valid && tmpl_ready_q) begin
                    tmpl_d[j_q] = bus.tmpl_data;
                    if (j_q == NW'(N - 1)) begin
                        state_d = WAIT_Q;
                        i_d     = '0;
                    end else begin
                        j_d = j_q + NW'(1);
                    end
                end
            end
            WAIT_Q: begin
                if (bus.qry_valid && qry_ready_q) begin
                    x_d       = bus.qry_data;
                    j_d       = NW'(j_lo);
                    row_min_d = CMAX;
                    for (int b = 0; b < BW; b++) begin
                        prev_d[b] = (i_q == '0) ? CMAX : cur_q[b];
                        cur_d[b]  = CMAX;
                    end
                    state_d = ROW;
                end
            end
            ROW: begin
                cur_d[k]  = cost;
                row_min_d = row_min_next;
                if (last_cell) begin
                    if (abandon_hit) begin
                        state_d     = DONE;
                        dist_data_d = CMAX;
                        abandoned_d = 1'b1;
                    end else if (i_q == NW'(N - 1)) begin
                        state_d     = DONE;
                        dist_data_d = cost;
                    end else begin
                        state_d = WAIT_Q;
                        i_d     = i_q + NW'(1);
                    end
                end else begin
                    j_d = j_q + NW'(1);
                end
            end
            DONE: begin
                if (bus.dist_ready && dist_valid_q) begin
                    state_d     = IDLE;
                    dist_data_d = '0;
                    abandoned_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        tmpl_ready_d = (state_d == LOAD_T);
        qry_ready_d  = (state_d == WAIT_Q);
        dist_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // State, storage and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int n = 0; n < N; n++) tmpl_q[n] <= '0;
            for (int b = 0; b < BW; b++) begin
                prev_q[b] <= '0;
                cur_q[b]  <= '0;
            end
            x_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            row_min_q    <= '0;
            tmpl_ready_q <= 1'b0;
            qry_ready_q  <= 1'b0;
            dist_valid_q <= 1'b0;
            dist_data_q  <= '0;
            busy_q       <= 1'b0;
            abandoned_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmpl_q       <= tmpl_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            x_q          <= x_d;
            i_q          <= i_d;
            j_q          <= j_d;
            row_min_q    <= row_min_d;
            tmpl_ready_q <= tmpl_ready_d;
            qry_ready_q  <= qry_ready_d;
            dist_valid_q <= dist_valid_d;
            dist_data_q  <= dist_data_d;
            busy_q       <= busy_d;
            abandoned_q  <= abandoned_d;
        end
    end

    assign bus.tmpl_ready = tmpl_ready_q;
    assign bus.qry_ready  = qry_ready_q;
    assign bus.dist_valid = dist_valid_q;
    assign bus.dist_data  = dist_data_q;
    assign bus.busy       = busy_q;
`ifdef DTW_EARLY_ABANDON_EN
    assign bus.abandoned  = abandoned_q;
`endif
endmodule

// File: doc/dtw_cell_engine.md
DTW_CELL_ENGINE -- requirements
Module: dtw_cell_engine

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter CWIDTH, default 16, accumulated-cost width in bits.
REQ-003 Parameter N, default 16, length of both sequences (N >= 2).
REQ-004 Parameter R, default 2, Sakoe-Chiba band half-width (1 <= R < N).
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin a comparison.
REQ-008 tmpl_valid / tmpl_ready  input / output  1 / 1  template sample handshake.
REQ-009 tmpl_data  input  WIDTH  template sample y[j], unsigned.
REQ-010 qry_valid / qry_ready  input / output  1 / 1  query sample handshake.
REQ-011 qry_data  input  WIDTH  query sample x[i], unsigned.
REQ-012 dist_valid / dist_ready  output / input  1 / 1  result handshake.
REQ-013 dist_data  output  CWIDTH  final DTW distance D(N-1,N-1).
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Transfer on any channel SHALL occur on a rising edge where valid and ready are both high.
REQ-016 FSM states SHALL be IDLE, LOAD_T, WAIT_Q, ROW, DONE.
REQ-017 IDLE: start -> LOAD_T; start SHALL be ignored in every other state.
REQ-018 LOAD_T: tmpl_ready=1; exactly N samples stored as y[0..N-1] in order; after the Nth transfer -> WAIT_Q.
REQ-019 WAIT_Q: qry_ready=1; transfer latches x[i], row i counter advances from 0, -> ROW next cycle.
REQ-020 ROW: one cell per cycle for j = max(0,i-R) .. min(N-1,i+R); after last cell -> WAIT_Q if i<N-1, else DONE.
REQ-021 Cell cost SHALL be D(i,j) = |x[i]-y[j]| + min(D(i-1,j-1), D(i-1,j), D(i,j-1)), absolute difference zero-extended to CWIDTH.
REQ-022 Out-of-band or out-of-matrix predecessors SHALL read as 2^CWIDTH-1; D(0,0) SHALL equal |x[0]-y[0]|.
REQ-023 Addition SHALL saturate at 2^CWIDTH-1 (no wrap).
REQ-024 Storage SHALL be limited to the template and two band-wide rows (2R+1 entries each), not a full N x N matrix.
REQ-025 DONE: dist_valid=1, dist_data=D(N-1,N-1), both held stable until dist_ready; transfer -> IDLE next cycle.
REQ-026 tmpl_ready, qry_ready, dist_valid SHALL be low outside their own state.
REQ-027 Row cycle count: 1 accept cycle + (cells in band) ROW cycles; no other stall cycles.

Reset
REQ-028 rst high at any edge, in any state, SHALL force IDLE, clear counters and row storage, and drive busy, tmpl_ready, qry_ready, dist_valid, dist_data to 0.
REQ-029 A comparison interrupted by rst SHALL produce no result; the next start begins a fresh template load.

Configuration
REQ-030 Macro DTW_EARLY_ABANDON_EN SHALL add input abandon_thresh [CWIDTH] and output abandoned [1].
REQ-031 With it defined: at end of each row, if min of that row's band values > abandon_thresh, skip remaining rows and enter DONE with dist_data = 2^CWIDTH-1, abandoned=1; abandoned clears on result transfer or rst.
REQ-032 Without it: ports absent, all N rows always computed.

Verification (N=4, R=1, WIDTH=8, CWIDTH=16 unless stated)
REQ-033 template 10,20,30,40, query 10,20,30,40 -> dist_data=0; ROW cell counts 2,3,3,2 per row.
REQ-034 template 0,0,0,0, query 5,5,5,5 -> dist_data=20.
REQ-035 CWIDTH=8, template all 0, query all 255 -> dist_data=255 (saturated), no wrap.
REQ-036 dist_ready held low 5 cycles in DONE -> dist_valid and dist_data stable; busy stays high; start pulses ignored.
REQ-037 rst asserted during row 2 ROW state -> next cycle IDLE, all outputs 0; new start + load yields correct result.
REQ-038 DTW_EARLY_ABANDON_EN, abandon_thresh=9, template all 0, query all 5 -> abandon after row 1, dist_data=65535, abandoned=1.
